datapath_pipe: RTL and testbench
================================

DATAPATH_PIPE -- requirements
Module: datapath_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/register width (>=4).
REQ-002 SHALL have parameter REG_COUNT, default 16, number of registers (power of two, >=4).
REQ-003 SHALL derive the local parameter ADDR_W = clog2(REG_COUNT).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk, in, 1, rising-edge clock; rst_n, in, 1, async active-low reset.
REQ-005 SHALL have these inputs: issue_valid (1, instruction present), hold (1, freeze pipeline), alu_opcode (3, ALU op), ra_addr/rb_addr/write_addr (ADDR_W each), write_en (1), write_alu (1, write ALU result), is_load (1, write ram_data), imm_flag (1, immediate select), imm_data/ram_data (DATA_W each).
REQ-006 SHALL have these outputs: issue_ready (1), read_a/read_b (DATA_W, forwarded operand views), alu_out (DATA_W), alu_zero/alu_carry (1, combinational EX flags), flag_zero/flag_carry (1, registered flags), ex_valid (1, EX stage occupied).

Function
REQ-007 SHALL hard-wire register 0 to 0: writes to it are discarded, reads return 0, and it is never forwarded.
REQ-008 SHALL accept an instruction at a rising edge when issue_valid && issue_ready, with issue_ready = !hold.
REQ-009 SHALL, on accept, capture opcode, dest, control bits, A = read_a, B = (write_alu && imm_flag) ? imm_data : read_b, load/imm data, and ex_valid<=1 (write_en=0 still occupies EX).
REQ-010 SHALL retire the EX instruction at the first rising edge with ex_valid && !hold, writing the selected data to dest when write_en && dest!=0; issue-to-visible latency is 1 cycle plus hold cycles.
REQ-011 SHALL select write data as follows: write_alu -> ALU result; else is_load -> ram_data; else imm_data.
REQ-012 SHALL clear ex_valid when retiring with no new accept in the same edge; a simultaneous retire and accept keeps ex_valid=1 (back-to-back, one instruction per cycle).
REQ-013 SHALL have hold=1 freeze the EX contents, the register file and the flags, with no retire and no accept.
REQ-014 SHALL make read_a/read_b asynchronous reads that bypass from EX when ex_valid && write_en && dest==addr && addr!=0, yielding EX write data.
REQ-015 SHALL implement ALU ops: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT(~A), 110 SHL(A<<1), 111 SHR(A>>1, logical), all modulo 2^DATA_W.
REQ-016 SHALL define carry as: ADD carry-out; SUB borrow (A<B unsigned); SHL A[MSB]; SHR A[0]; logic ops 0.
REQ-017 SHALL define alu_zero = (alu_out==0) and compute alu_out/alu_zero/alu_carry from the EX register every cycle, regardless of ex_valid.
REQ-018 SHALL update flag_zero/flag_carry only when an instruction with write_alu=1 retires; loads and immediates leave the flags unchanged.

Reset
REQ-019 SHALL, while rst_n=0, immediately clear all registers, EX contents, ex_valid, flag_zero and flag_carry to 0; issue_ready then follows hold.
REQ-020 SHALL, on reset assertion mid-operation, discard the EX instruction with no write at reset release.
REQ-021 SHALL accept no instruction on the first rising edge at which rst_n is low.

Structure
REQ-022 SHALL place the opcode constants (ADD..SHR) and opcode width in shared package datapath_pkg.
REQ-023 SHALL implement the ALU as combinational sub-module dp_alu (parameter DATA_W; ports a, b, opcode, result, zero, carry).
REQ-024 SHALL keep the register file, forwarding and EX register inside datapath_pipe, with no further sub-modules.

Verification
REQ-025 SHALL verify immediate fill: write r_i = i*0x11 for i=0..15, then read pairs (i, 15-i) -> r0 reads 00, all others match.
REQ-026 SHALL verify back-to-back forwarding: r1=0, r2=1, then 64 consecutive ADD r1=r1+r2 with no hold -> r1=0x40, flag_carry=0.
REQ-027 SHALL verify SUB wrap: r12=0x7F, r6=0x0A, then 13 consecutive SUB r12-=r6 -> r12=0xFD (0x7F-0x82), flag_carry=1 at the wrapping step.
REQ-028 SHALL verify ADDI: r5=0x0F, imm_flag=1, imm_data=0x0C, ADD into r1 -> r1=0x1B, flag_zero=0.
REQ-029 SHALL verify hold: ADD into r3 with hold=1 for 3 cycles -> r3 unchanged, issue_ready=0, ex_valid=1; after release -> r3 written, flags updated once.
REQ-030 SHALL verify reset and r0: rst_n pulsed low while ex_valid=1 -> all registers 00, no write after release; write 0xAA to r0 -> r0 reads 00.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared ALU opcode encoding and EX-stage control bundle for the datapath pipeline.
package datapath_pkg;

    localparam int OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
        logic    write_en;
        logic    write_alu;
        logic    is_load;
    } ex_ctrl_t;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: eight ops modulo 2^DATA_W with carry/borrow/shift-out flag.
module dp_alu
    import datapath_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [DATA_W-1:0]   result,
    output logic                zero,
    output logic                carry
);

    logic [DATA_W:0] sum_ext;

    assign sum_ext = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (alu_op_e'(opcode))
            OP_ADD: begin
                result = sum_ext[DATA_W-1:0];
                carry  = sum_ext[DATA_W];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage datapath: register file with EX bypass, single EX register, ALU and flags.
module datapath_pipe
    import datapath_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int REG_COUNT = 16,
    localparam int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic                hold,
    input  logic [OPCODE_W-1:0] alu_opcode,
    input  logic [ADDR_W-1:0]   ra_addr,
    input  logic [ADDR_W-1:0]   rb_addr,
    input  logic [ADDR_W-1:0]   write_addr,
    input  logic                write_en,
    input  logic                write_alu,
    input  logic                is_load,
    input  logic                imm_flag,
    input  logic [DATA_W-1:0]   imm_data,
    input  logic [DATA_W-1:0]   ram_data,
    output logic                issue_ready,
    output logic [DATA_W-1:0]   read_a,
    output logic [DATA_W-1:0]   read_b,
    output logic [DATA_W-1:0]   alu_out,
    output logic                alu_zero,
    output logic                alu_carry,
    output logic                flag_zero,
    output logic                flag_carry,
    output logic                ex_valid
);

    logic [DATA_W-1:0]    rf_reg [REG_COUNT];
    logic [REG_COUNT-1:0] row_we;

    logic                 ex_valid_reg;
    logic                 ex_valid_next;
    ex_ctrl_t             ex_ctrl_reg;
    logic [ADDR_W-1:0]    ex_dest_reg;
    logic [DATA_W-1:0]    ex_a_reg;
    logic [DATA_W-1:0]    ex_b_reg;
    logic [DATA_W-1:0]    ex_imm_reg;
    logic [DATA_W-1:0]    ex_ram_reg;
    logic                 flag_zero_reg;
    logic                 flag_carry_reg;

    logic                 accept;
    logic                 retire;
    logic                 rf_we;
    logic                 fwd_a;
    logic                 fwd_b;
    logic [DATA_W-1:0]    ex_wdata;
    logic [DATA_W-1:0]    alu_result;
    logic                 alu_z;
    logic                 alu_c;

    assign issue_ready = !hold;
    assign accept      = issue_valid && !hold;
    assign retire      = ex_valid_reg && !hold;
    assign rf_we       = retire && ex_ctrl_reg.write_en;

    dp_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (ex_a_reg),
        .b      (ex_b_reg),
        .opcode (ex_ctrl_reg.op),
        .result (alu_result),
        .zero   (alu_z),
        .carry  (alu_c)
    );

    always_comb begin
        ex_wdata = ex_imm_reg;
        if (ex_ctrl_reg.write_alu) begin
            ex_wdata = alu_result;
        end else if (ex_ctrl_reg.is_load) begin
            ex_wdata = ex_ram_reg;
        end
    end

    // Row 0 never gets a write strobe, so it stays at its reset value of zero.
    generate
        for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_row_we
            if (gi == 0) begin : g_zero
                assign row_we[gi] = 1'b0;
            end else begin : g_row
                assign row_we[gi] = rf_we && (ex_dest_reg == ADDR_W'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (row_we[i]) begin
                    rf_reg[i] <= ex_wdata;
                end
            end
        end
    end

    // Bypass the in-flight write so back-to-back dependents see it without a stall.
    assign fwd_a  = ex_valid_reg && ex_ctrl_reg.write_en && (ex_dest_reg == ra_addr) && (ra_addr != '0);
    assign fwd_b  = ex_valid_reg && ex_ctrl_reg.write_en && (ex_dest_reg == rb_addr) && (rb_addr != '0);
    assign read_a = fwd_a ? ex_wdata : rf_reg[ra_addr];
    assign read_b = fwd_b ? ex_wdata : rf_reg[rb_addr];

    always_comb begin
        ex_valid_next = ex_valid_reg;
        if (accept) begin
            ex_valid_next = 1'b1;
        end else if (retire) begin
            ex_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg <= 1'b0;
            ex_ctrl_reg  <= '0;
            ex_dest_reg  <= '0;
            ex_a_reg     <= '0;
            ex_b_reg     <= '0;
            ex_imm_reg   <= '0;
            ex_ram_reg   <= '0;
        end else begin
            ex_valid_reg <= ex_valid_next;
            if (accept) begin
                ex_ctrl_reg.op        <= alu_op_e'(alu_opcode);
                ex_ctrl_reg.write_en  <= write_en;
                ex_ctrl_reg.write_alu <= write_alu;
                ex_ctrl_reg.is_load   <= is_load;
                ex_dest_reg           <= write_addr;
                ex_a_reg              <= read_a;
                ex_b_reg              <= (write_alu && imm_flag) ? imm_data : read_b;
                ex_imm_reg            <= imm_data;
                ex_ram_reg            <= ram_data;
            end
        end
    end

    // Only ALU results touch the flags; loads and immediates pass through untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_zero_reg  <= 1'b0;
            flag_carry_reg <= 1'b0;
        end else if (retire && ex_ctrl_reg.write_alu) begin
            flag_zero_reg  <= alu_z;
            flag_carry_reg <= alu_c;
        end
    end

    assign alu_out    = alu_result;
    assign alu_zero   = alu_z;
    assign alu_carry  = alu_c;
    assign flag_zero  = flag_zero_reg;
    assign flag_carry = flag_carry_reg;
    assign ex_valid   = ex_valid_reg;

endmodule

// File: tb/tb_datapath_pipe.sv
// Scoreboard bench: driver runs a sequential architectural model, monitor checks accepts and retires.
module tb_datapath_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_valid = 1'b0;
    logic       hold = 1'b0;
    logic [2:0] alu_opcode = '0;
    logic [3:0] ra_addr = '0, rb_addr = '0, write_addr = '0;
    logic       write_en = 1'b0, write_alu = 1'b0, is_load = 1'b0, imm_flag = 1'b0;
    logic [7:0] imm_data = '0, ram_data = '0;
    logic       issue_ready;
    logic [7:0] read_a, read_b, alu_out;
    logic       alu_zero, alu_carry, flag_zero, flag_carry, ex_valid;

    datapath_pipe #(.DATA_W(8), .REG_COUNT(16)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .hold(hold),
        .alu_opcode(alu_opcode), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .write_addr(write_addr), .write_en(write_en), .write_alu(write_alu),
        .is_load(is_load), .imm_flag(imm_flag), .imm_data(imm_data),
        .ram_data(ram_data), .issue_ready(issue_ready), .read_a(read_a),
        .read_b(read_b), .alu_out(alu_out), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .flag_zero(flag_zero), .flag_carry(flag_carry),
        .ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    typedef struct { int a; int b; } opnd_t;
    typedef struct { int res; int z; int c; int fz; int fc; } ret_t;

    opnd_t opnd_q[$];
    ret_t  ret_q[$];
    int    m_reg [16];
    int    m_fz, m_fc;
    int    vectors = 0;
    int    miscompares = 0;
    int    pend = 0;
    int    pend_fz, pend_fc;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_alu(input int op, input int a, input int b, output int res, output int c);
        c = 0;
        case (op)
            0: begin res = (a + b) % 256; c = ((a + b) > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = 255 - a;
            6: begin res = (a * 2) % 256; c = a / 128; end
            default: begin res = a / 2; c = a % 2; end
        endcase
    endfunction

    // Monitor: operand views at accept, ALU outputs at retire, flags one cycle after retire.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend != 0) begin
                check("flag_zero", int'(flag_zero), pend_fz);
                check("flag_carry", int'(flag_carry), pend_fc);
                pend = 0;
            end
            if (issue_valid && issue_ready) begin
                if (opnd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL accept_unexpected: got accept expected none");
                end else begin
                    opnd_t o;
                    o = opnd_q.pop_front();
                    check("read_a", int'(read_a), o.a);
                    check("read_b", int'(read_b), o.b);
                end
            end
            if (ex_valid && !hold) begin
                if (ret_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL retire_unexpected: got retire expected none");
                end else begin
                    ret_t r;
                    r = ret_q.pop_front();
                    check("alu_out", int'(alu_out), r.res);
                    check("alu_zero", int'(alu_zero), r.z);
                    check("alu_carry", int'(alu_carry), r.c);
                    pend = 1;
                    pend_fz = r.fz;
                    pend_fc = r.fc;
                end
            end
        end
    end

    task automatic issue(input int op, input int ra, input int rb, input int dest, input int we,
                         input int walu, input int ld, input int immf, input int imm, input int ram);
        int a, bv, b, res, c, wd;
        opnd_t o;
        ret_t r;
        issue_valid = 1'b1; hold = 1'b0;
        alu_opcode = 3'(op); ra_addr = 4'(ra); rb_addr = 4'(rb); write_addr = 4'(dest);
        write_en = 1'(we); write_alu = 1'(walu); is_load = 1'(ld); imm_flag = 1'(immf);
        imm_data = 8'(imm); ram_data = 8'(ram);
        a  = m_reg[ra];
        bv = m_reg[rb];
        b  = (walu != 0 && immf != 0) ? imm : bv;
        model_alu(op, a, b, res, c);
        wd = (walu != 0) ? res : ((ld != 0) ? ram : imm);
        if (we != 0 && dest != 0) m_reg[dest] = wd;
        if (walu != 0) begin m_fz = (res == 0) ? 1 : 0; m_fc = c; end
        o.a = a; o.b = bv;
        r.res = res; r.z = (res == 0) ? 1 : 0; r.c = c; r.fz = m_fz; r.fc = m_fc;
        opnd_q.push_back(o);
        ret_q.push_back(r);
        $display("issue op=%0d ra=%0d rb=%0d rd=%0d we=%0d alu=%0d ld=%0d imm=%0d:%02h -> wd=%02h",
                 op, ra, rb, dest, we, walu, ld, immf, imm, wd);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        issue_valid = 1'b0;
        hold = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int budget = 50;
        issue_valid = 1'b0;
        hold = 1'b0;
        while ((ret_q.size() != 0 || opnd_q.size() != 0) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) check("drain_timeout", ret_q.size(), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic peek(input string name, input int addr, input int exp);
        issue_valid = 1'b0;
        ra_addr = 4'(addr);
        @(negedge clk);
        check(name, int'(read_a), exp);
        @(posedge clk); #1;
    endtask

    task automatic hold_cycles(input int n);
        hold = 1'b1;
        repeat (n) begin
            issue_valid = 1'($urandom_range(0, 1));
            alu_opcode = 3'($urandom);
            write_addr = 4'($urandom);
            ra_addr = 4'($urandom);
            rb_addr = 4'($urandom);
            @(posedge clk); #1;
        end
        hold = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_reg[i] = 0;
        m_fz = 0; m_fc = 0;
        // An instruction is presented throughout reset; none may be accepted.
        issue_valid = 1'b1; write_en = 1'b1; write_addr = 4'd9; imm_data = 8'h33;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_ex_valid", int'(ex_valid), 0);
        check("reset_flag_zero", int'(flag_zero), 0);
        check("reset_issue_ready", int'(issue_ready), 1);
        issue_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_ex_valid", int'(ex_valid), 0);
        peek("reset_r9", 9, 0);

        // Immediate fill then crossed read pairs.
        for (int i = 0; i < 16; i++) issue(0, 0, 0, i, 1, 0, 0, 0, i * 17, 0);
        for (int i = 0; i < 16; i++) issue(3, i, 15 - i, 0, 0, 0, 0, 0, 0, 0);
        drain();

        // Back-to-back forwarded accumulation.
        issue(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 2, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 64; i++) issue(0, 1, 2, 1, 1, 1, 0, 0, 0, 0);
        drain();
        peek("add64_r1", 1, 'h40);
        check("add64_carry", int'(flag_carry), 0);

        // Repeated subtraction wrapping through zero.
        issue(0, 0, 0, 12, 1, 0, 0, 0, 'h7F, 0);
        issue(0, 0, 0, 6, 1, 0, 0, 0, 'h0A, 0);
        for (int i = 0; i < 13; i++) issue(1, 12, 6, 12, 1, 1, 0, 0, 0, 0);
        drain();
        peek("sub_r12", 12, 'hFD);
        check("sub_carry", int'(flag_carry), 1);

        // Add immediate.
        issue(0, 0, 0, 5, 1, 0, 0, 0, 'h0F, 0);
        issue(0, 5, 9, 1, 1, 1, 0, 1, 'h0C, 0);
        drain();
        peek("addi_r1", 1, 'h1B);
        check("addi_zero", int'(flag_zero), 0);

        // Hold freezes EX for three cycles, then the ADD retires exactly once.
        issue(0, 1, 2, 3, 1, 1, 0, 0, 0, 0);
        hold = 1'b1; issue_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_ready", int'(issue_ready), 0);
            check("hold_ex_valid", int'(ex_valid), 1);
            @(posedge clk); #1;
        end
        drain();
        peek("hold_r3", 3, 'h1C);

        // Randomized traffic with sporadic hold bursts.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) hold_cycles($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) idle(1);
            issue($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255),
                  $urandom_range(0, 255));
        end
        drain();

        // Reset while EX holds a pending write to r7; the write must be lost.
        issue(0, 0, 0, 7, 1, 0, 0, 0, 'h55, 0);
        hold = 1'b1; issue_valid = 1'b0; ra_addr = 4'd7;
        @(negedge clk);
        check("pre_reset_ex_valid", int'(ex_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        opnd_q.delete();
        ret_q.delete();
        for (int i = 0; i < 16; i++) m_reg[i] = 0;
        m_fz = 0; m_fc = 0;
        check("async_ex_valid", int'(ex_valid), 0);
        check("async_flag_carry", int'(flag_carry), 0);
        check("async_read_r7", int'(read_a), 0);
        @(posedge clk); #1;
        hold = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i += 2) issue(4, i, i + 1, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 1, 0, 0, 0, 'hAA, 0);
        issue(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();
        peek("r0_after_write", 0, 0);
        peek("r7_after_reset", 7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
